// File: rtl/spi_regs_master.sv
// SPI mode-0 initiator for 16-bit register frames {rd, addr[6:0], data[7:0]}; start to done takes 1+CS_SETUP+32*CLK_DIV+CS_HOLD cycles.
// No queueing: start is sampled only while idle, and busy stays high through the CS gap.
module spi_regs_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic       FX2_CLK,
  input  logic       reset,
  input  logic       start,
  input  logic       rd,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       CS,
  output logic       SCK,
  output logic       SI,
  input  logic       SO
);

  typedef logic [15:0] cnt_t;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam cnt_t SETUP_LAST = cnt_t'(CS_SETUP - 1);
  localparam cnt_t DIV_LAST   = cnt_t'(CLK_DIV - 1);
  localparam cnt_t HOLD_LAST  = cnt_t'(CS_HOLD - 1);
  localparam cnt_t GAP_LAST   = cnt_t'(CS_GAP - 1);

  state_t      state;
  cnt_t        cnt;
  logic [4:0]  bit_cnt;
  logic [14:0] sh;
  logic [7:0]  rx;
  logic        rd_q;

  always_ff @(posedge FX2_CLK or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      sh      <= '0;
      rx      <= '0;
      rd_q    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
      CS      <= 1'b0;
      SCK     <= 1'b0;
      SI      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Frame bit 15 (rd) goes straight to SI; the remaining 15 bits wait in sh.
            sh      <= {addr, rd ? 8'h00 : wdata};
            SI      <= rd;
            rd_q    <= rd;
            CS      <= 1'b1;
            busy    <= 1'b1;
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            SCK <= ~SCK;
            if (SCK) begin
              // Falling edge: advance SI and, in the data byte, capture SO.
              bit_cnt <= bit_cnt + 1'b1;
              sh      <= {sh[13:0], 1'b0};
              SI      <= sh[14];
              if (bit_cnt >= 5'd8) rx <= {rx[6:0], SO};
              if (bit_cnt == 5'd15) state <= HOLD;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt   <= '0;
            CS    <= 1'b0;
            done  <= 1'b1;
            if (rd_q) rdata <= rx;
            state <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_regs_master.sv
// Bench for spi_regs_master: two instances (CLK_DIV=4 and CLK_DIV=2), directed stimulus,
// expected frames/read data queued per transaction and checked by a monitor on each done.
module tb_spi_regs_master;

  typedef struct packed {
    logic [15:0] frame;
    logic [7:0]  rdata;
  } exp_t;

  localparam int HOLD_C = 2;
  localparam int GAP_C  = 4;

  logic       FX2_CLK = 1'b0;
  logic       reset   = 1'b0;
  logic       start_s [2];
  logic       rd_s    [2];
  logic [6:0] addr_s  [2];
  logic [7:0] wdata_s [2];
  logic       busy [2];
  logic       done [2];
  logic [7:0] rdata [2];
  logic       cs [2];
  logic       sck [2];
  logic       si [2];
  logic       so [2];

  logic       so_mode  [2];
  logic       so_const [2];
  logic [7:0] so_byte  [2];

  exp_t q0[$];
  exp_t q1[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int tmo = 0;
  int rst_req = 0, rst_served = 0;
  int fin_req = 0, fin_served = 0;

  int   rises [2], bad_w [2], glitch [2];
  int   cs_rise_c [2], cs_fall_c [2], last_fall_c [2], hi_start_c [2], done_c [2];
  logic [15:0] sib [2];
  logic cs_p [2], sck_p [2], si_p [2], busy_p [2], done_p [2];

  spi_regs_master #(.CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2), .CS_GAP(4)) dut0 (
    .FX2_CLK(FX2_CLK), .reset(reset), .start(start_s[0]), .rd(rd_s[0]),
    .addr(addr_s[0]), .wdata(wdata_s[0]), .busy(busy[0]), .done(done[0]),
    .rdata(rdata[0]), .CS(cs[0]), .SCK(sck[0]), .SI(si[0]), .SO(so[0])
  );

  spi_regs_master #(.CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2), .CS_GAP(4)) dut1 (
    .FX2_CLK(FX2_CLK), .reset(reset), .start(start_s[1]), .rd(rd_s[1]),
    .addr(addr_s[1]), .wdata(wdata_s[1]), .busy(busy[1]), .done(done[1]),
    .rdata(rdata[1]), .CS(cs[1]), .SCK(sck[1]), .SI(si[1]), .SO(so[1])
  );

  always #5 FX2_CLK = ~FX2_CLK;
  always @(posedge FX2_CLK) cyc <= cyc + 1;

  function automatic int div_of(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  // Hand-computed 1 + CS_SETUP + 32*CLK_DIV + CS_HOLD per instance.
  function automatic int lat_of(input int i);
    return (i == 0) ? 133 : 69;
  endfunction

  task automatic check(input string nm, input int inst, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s[%0d]: got 'h%0h, expected 'h%0h", nm, inst, act, req);
    end
  endtask

  // Monitor: SO slave model, edge bookkeeping, scoreboard pops on done.
  always @(negedge FX2_CLK) begin
    exp_t       e;
    logic [2:0] idx;
    if (rst_req != rst_served) begin
      for (int i = 0; i < 2; i++) begin
        check("rst_cs", i, int'(cs[i]), 0);
        check("rst_sck", i, int'(sck[i]), 0);
        check("rst_si", i, int'(si[i]), 0);
        check("rst_busy", i, int'(busy[i]), 0);
        check("rst_done", i, int'(done[i]), 0);
        check("rst_rdata", i, int'(rdata[i]), 0);
      end
      rst_served = rst_req;
    end
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        if (i == 0) q0.delete(); else q1.delete();
        so[i] = 1'b0;
        rises[i] = 0; bad_w[i] = 0; glitch[i] = 0; sib[i] = '0;
        cs_rise_c[i] = 0; cs_fall_c[i] = -1; last_fall_c[i] = -1;
        hi_start_c[i] = 0; done_c[i] = -1000;
      end else begin
        if (so_mode[i]) so[i] = so_const[i];
        if (cs[i] && !cs_p[i]) begin
          check("busy_with_cs", i, int'(busy[i]), 1);
          if (cs_fall_c[i] >= 0) check("cs_gap_ok", i, int'((cyc - cs_fall_c[i]) >= GAP_C), 1);
          cs_rise_c[i] = cyc; rises[i] = 0; sib[i] = '0;
          bad_w[i] = 0; glitch[i] = 0; last_fall_c[i] = -1;
          if (!so_mode[i]) so[i] = 1'b1;
        end
        if (sck[i] && !sck_p[i]) begin
          rises[i]++;
          sib[i] = {sib[i][14:0], si[i]};
          if (last_fall_c[i] >= 0 && (cyc - last_fall_c[i]) != div_of(i)) bad_w[i]++;
          hi_start_c[i] = cyc;
          if (!so_mode[i] && rises[i] >= 9 && rises[i] <= 16) begin
            idx = 3'(16 - rises[i]);
            so[i] = so_byte[i][idx];
          end
        end
        if (!sck[i] && sck_p[i]) begin
          if ((cyc - hi_start_c[i]) != div_of(i)) bad_w[i]++;
          last_fall_c[i] = cyc;
        end
        if (si[i] != si_p[i] && !(!sck[i] && sck_p[i]) && !(cs[i] && !cs_p[i])) glitch[i]++;
        if (!cs[i] && cs_p[i]) begin
          check("cs_hold", i, cyc - last_fall_c[i], HOLD_C);
          cs_fall_c[i] = cyc;
        end
        if (done[i]) begin
          check("done_pulse", i, int'(done_p[i]), 0);
          if ((i == 0 ? q0.size() : q1.size()) == 0) begin
            check("unexpected_done", i, 1, 0);
          end else begin
            if (i == 0) e = q0.pop_front(); else e = q1.pop_front();
            check("rdata", i, int'(rdata[i]), int'(e.rdata));
            check("si_frame", i, int'(sib[i]), int'(e.frame));
            check("sck_rises", i, rises[i], 16);
            check("sck_widths_bad", i, bad_w[i], 0);
            check("si_glitches", i, glitch[i], 0);
            check("latency", i, cyc - (cs_rise_c[i] - 1), lat_of(i));
          end
          done_c[i] = cyc;
        end
        if (!busy[i] && busy_p[i]) check("busy_tail", i, cyc - done_c[i], GAP_C);
      end
      cs_p[i] = cs[i]; sck_p[i] = sck[i]; si_p[i] = si[i];
      busy_p[i] = busy[i]; done_p[i] = done[i];
    end
    if (fin_req != fin_served) begin
      check("pending_q0", 0, q0.size(), 0);
      check("pending_q1", 1, q1.size(), 0);
      check("timeouts", 0, tmo, 0);
      fin_served = fin_req;
    end
  end

  task automatic wait_busy(input int i, input logic v);
    int t = 0;
    while (busy[i] !== v && t < 3000) begin
      @(negedge FX2_CLK);
      t++;
    end
    if (t >= 3000) tmo++;
  endtask

  task automatic issue(input int i, input logic r, input logic [6:0] a, input logic [7:0] w,
                       input logic [15:0] ef, input logic [7:0] er);
    exp_t e;
    wait_busy(i, 1'b0);
    rd_s[i] = r; addr_s[i] = a; wdata_s[i] = w; start_s[i] = 1'b1;
    e.frame = ef; e.rdata = er;
    if (i == 0) q0.push_back(e); else q1.push_back(e);
    @(negedge FX2_CLK);
    start_s[i] = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   r, t;
    logic p;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; rd_s[i] = 1'b0; addr_s[i] = '0; wdata_s[i] = '0;
      so_mode[i] = 1'b0; so_const[i] = 1'b0; so_byte[i] = 8'h00;
    end
    #2 reset = 1'b1;
    repeat (2) @(negedge FX2_CLK);
    rst_req++;
    repeat (2) @(negedge FX2_CLK);
    reset = 1'b0;
    @(negedge FX2_CLK);

    issue(0, 1'b0, 7'h05, 8'hA5, 16'h05A5, 8'h00);
    wait_busy(0, 1'b0);
    so_byte[0] = 8'h3C;
    issue(0, 1'b1, 7'h03, 8'h00, 16'h8300, 8'h3C);
    wait_busy(0, 1'b0);
    issue(0, 1'b0, 7'h01, 8'hFF, 16'h01FF, 8'h3C);
    wait_busy(0, 1'b0);

    // Reset while SCK is high after rising edge 6.
    issue(0, 1'b0, 7'h02, 8'h33, 16'h0233, 8'h3C);
    r = 0; t = 0; p = 1'b0;
    while (r < 6 && t < 3000) begin
      @(negedge FX2_CLK);
      if (sck[0] && !p) r++;
      p = sck[0];
      t++;
    end
    if (t >= 3000) tmo++;
    @(posedge FX2_CLK);
    #1 reset = 1'b1;
    rst_req++;
    repeat (3) @(negedge FX2_CLK);
    reset = 1'b0;
    @(negedge FX2_CLK);
    issue(0, 1'b0, 7'h01, 8'hFF, 16'h01FF, 8'h00);
    wait_busy(0, 1'b0);

    so_mode[0] = 1'b1; so_const[0] = 1'b1;
    issue(0, 1'b1, 7'h03, 8'h00, 16'h8300, 8'hFF);
    wait_busy(0, 1'b0);
    so_const[0] = 1'b0;
    issue(0, 1'b1, 7'h03, 8'h00, 16'h8300, 8'h00);
    wait_busy(0, 1'b0);
    so_mode[0] = 1'b0;

    // Second start while busy must be dropped.
    issue(0, 1'b0, 7'h0A, 8'h5A, 16'h0A5A, 8'h00);
    repeat (20) @(negedge FX2_CLK);
    rd_s[0] = 1'b1; addr_s[0] = 7'h7F; start_s[0] = 1'b1;
    @(negedge FX2_CLK);
    start_s[0] = 1'b0;
    wait_busy(0, 1'b0);

    // start held high: two frames separated by the full gap.
    rd_s[0] = 1'b0; addr_s[0] = 7'h11; wdata_s[0] = 8'h22; start_s[0] = 1'b1;
    e.frame = 16'h1122; e.rdata = 8'h00;
    q0.push_back(e);
    q0.push_back(e);
    wait_busy(0, 1'b1);
    wait_busy(0, 1'b0);
    wait_busy(0, 1'b1);
    start_s[0] = 1'b0;
    wait_busy(0, 1'b0);

    issue(1, 1'b0, 7'h05, 8'hA5, 16'h05A5, 8'h00);
    wait_busy(1, 1'b0);
    so_byte[1] = 8'h3C;
    issue(1, 1'b1, 7'h03, 8'h00, 16'h8300, 8'h3C);
    wait_busy(1, 1'b0);

    repeat (5) @(negedge FX2_CLK);
    fin_req++;
    repeat (3) @(negedge FX2_CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
